// File: rtl/shim_abs_sample_collector.sv
// shim_abs_sample_collector: gathers 8 channel samples as saturated abs values and publishes them as one atomic frame
module shim_abs_sample_collector #(
    parameter bit          OFFSET_BINARY  = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         sample_valid,
    input  logic [2:0]   sample_ch,
    input  logic [15:0]  sample_data,
    output logic [119:0] abs_sample_concat,
    output logic         frame_valid,
    output logic         err_dup,
    output logic         err_timeout
);
    typedef enum logic [1:0] {IDLE, COLLECT, ERROR} state_t;
    state_t        state;
    logic [7:0]    got_mask;
    logic [31:0]   timer;
    logic [14:0]   shadow [8];
    logic [15:0]   x;
    logic [15:0]   neg;
    logic [14:0]   abs_val;
    logic [7:0]    ch_bit;
    logic [7:0]    next_mask;
    logic          accept;
    logic          dup;
    logic          complete;
    logic          timeout;
    logic [119:0]  frame;
    assign x         = {sample_data[15] ^ OFFSET_BINARY, sample_data[14:0]};
    assign neg       = -x;
    assign abs_val   = !x[15] ? x[14:0] : (x == 16'h8000 ? 15'h7FFF : neg[14:0]);
    assign ch_bit    = 8'd1 << sample_ch;
    assign accept    = state == COLLECT && sample_valid;
    assign dup       = accept && (got_mask & ch_bit) != 8'd0;
    assign next_mask = got_mask | ch_bit;
    assign complete  = accept && !dup && next_mask == 8'hFF;
    assign timeout   = state == COLLECT && got_mask != 8'd0 && timer == TIMEOUT_CYCLES && !complete;
    // The completing sample bypasses its shadow so the frame publishes on the same edge
    for (genvar i = 0; i < 8; i++) begin : g_frame
        assign frame[15*i +: 15] = (sample_ch == 3'(i)) ? abs_val : shadow[i];
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            got_mask          <= 8'd0;
            timer             <= 32'd0;
            abs_sample_concat <= 120'd0;
            frame_valid       <= 1'b0;
            err_dup           <= 1'b0;
            err_timeout       <= 1'b0;
            for (int k = 0; k < 8; k++) shadow[k] <= 15'd0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    got_mask <= 8'd0;
                    timer    <= 32'd0;
                    if (enable) state <= COLLECT;
                end
                COLLECT: begin
                    if (accept && !dup) shadow[sample_ch] <= abs_val;
                    if (dup) err_dup <= 1'b1;
                    if (timeout) err_timeout <= 1'b1;
                    if (complete) begin
                        abs_sample_concat <= frame;
                        frame_valid       <= 1'b1;
                    end
                    if (dup || timeout) state <= ERROR;
                    else if (!enable) state <= IDLE;
                    got_mask <= (complete || !enable) ? 8'd0 : (accept && !dup) ? next_mask : got_mask;
                    timer    <= (complete || !enable) ? 32'd0 :
                                (accept && got_mask == 8'd0) ? 32'd1 :
                                (got_mask != 8'd0) ? timer + 32'd1 : timer;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shim_abs_sample_collector.sv
// tb_shim_abs_sample_collector: directed checks of abs conversion, framing, timeout and duplicate faults
module tb_shim_abs_sample_collector;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         sample_valid = 1'b0;
    logic [2:0]   sample_ch = 3'd0;
    logic [15:0]  sample_data = 16'd0;
    logic [119:0] concat0, concat1;
    logic         fv0, fv1, dup0, dup1, to0, to1;
    int           passed = 0;
    int           total = 0;

    always #5 clk = ~clk;

    shim_abs_sample_collector #(.OFFSET_BINARY(1'b0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .resetn(resetn), .enable(enable), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data), .abs_sample_concat(concat0),
        .frame_valid(fv0), .err_dup(dup0), .err_timeout(to0));
    shim_abs_sample_collector #(.OFFSET_BINARY(1'b1), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .resetn(resetn), .enable(enable), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data), .abs_sample_concat(concat1),
        .frame_valid(fv1), .err_dup(dup1), .err_timeout(to1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [15:0] d);
        sample_valid = 1'b1;
        sample_ch    = c;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    // Reset, then enable with a sample in the enabling cycle that must be ignored
    task automatic start();
        resetn = 1'b0;
        enable = 1'b0;
        sample_valid = 1'b0;
        step();
        resetn = 1'b1;
        enable = 1'b1;
        send(3'd0, 16'd999);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        total++; if ({concat0, fv0, dup0, to0} !== 123'd0) $display("FAIL reset_outputs got %h", {concat0, fv0, dup0, to0}); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_twos();
        logic [15:0]  d [8];
        logic [14:0]  e [8];
        logic [119:0] exp;
        d = '{16'd100, 16'hFF9C, 16'h7FFF, 16'h8001, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001};
        e = '{15'd100, 15'd100, 15'd32767, 15'd32767, 15'd32767, 15'd0, 15'd1, 15'd1};
        for (int i = 0; i < 8; i++) exp[15*i +: 15] = e[i];
        start();
        for (int i = 0; i < 8; i++) begin
            total++; if (fv0 !== 1'b0) $display("FAIL twos_early_fv ch%0d got %b want 0", i, fv0); else passed++;
            send(3'(i), d[i]);
        end
        total++; if (fv0 !== 1'b1) $display("FAIL twos_fv got %b want 1", fv0); else passed++;
        total++; if (concat0 !== exp) $display("FAIL twos_concat got %h want %h", concat0, exp); else passed++;
        total++; if (dup0 !== 1'b0) $display("FAIL twos_ignored_idle_sample err_dup got %b want 0", dup0); else passed++;
        step();
        total++; if (fv0 !== 1'b0) $display("FAIL twos_fv_pulse got %b want 0", fv0); else passed++;
        total++; if (concat0 !== exp) $display("FAIL twos_hold got %h want %h", concat0, exp); else passed++;
    endtask

    task automatic test_offset();
        logic [119:0] exp;
        exp = {5{15'd5}};
        exp = {exp[74:0], 15'd32767, 15'd32767, 15'd0};
        start();
        send(3'd0, 16'h8000);
        send(3'd1, 16'h0000);
        send(3'd2, 16'hFFFF);
        for (int i = 3; i < 8; i++) send(3'(i), 16'h8005);
        total++; if (fv1 !== 1'b1) $display("FAIL offset_fv got %b want 1", fv1); else passed++;
        total++; if (concat1 !== exp) $display("FAIL offset_concat got %h want %h", concat1, exp); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [119:0] exp;
        for (int i = 0; i < 8; i++) exp[15*i +: 15] = 15'(i * 20 + 1);
        start();
        for (int i = 7; i >= 0; i--) send(3'(i), 16'(i * 10));
        total++; if (fv0 !== 1'b1) $display("FAIL b2b_first_fv got %b want 1", fv0); else passed++;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 16'(i * 20 + 1));
            total++; if (fv0 !== (i == 7)) $display("FAIL b2b_second_fv idx%0d got %b want %b", i, fv0, i == 7); else passed++;
        end
        total++; if (concat0 !== exp) $display("FAIL b2b_concat got %h want %h", concat0, exp); else passed++;
        total++; if ({dup0, to0} !== 2'b00) $display("FAIL b2b_errors got %b want 00", {dup0, to0}); else passed++;
    endtask

    task automatic test_dup();
        logic seen_fv;
        start();
        for (int i = 0; i < 4; i++) send(3'(i), 16'd7);
        total++; if (dup0 !== 1'b0) $display("FAIL dup_early got %b want 0", dup0); else passed++;
        send(3'd3, 16'd8);
        total++; if (dup0 !== 1'b1) $display("FAIL dup_flag got %b want 1", dup0); else passed++;
        seen_fv = 1'b0;
        for (int i = 4; i < 8; i++) begin
            send(3'(i), 16'd9);
            seen_fv |= fv0;
        end
        enable = 1'b0;
        step();
        total++; if (seen_fv !== 1'b0) $display("FAIL dup_no_frame got %b want 0", seen_fv); else passed++;
        total++; if (concat0 !== 120'd0) $display("FAIL dup_concat_hold got %h want 0", concat0); else passed++;
        total++; if (dup0 !== 1'b1) $display("FAIL dup_sticky got %b want 1", dup0); else passed++;
        resetn = 1'b0;
        #2;
        total++; if (dup0 !== 1'b0) $display("FAIL dup_reset_clear got %b want 0", dup0); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_timeout();
        start();
        for (int i = 0; i < 7; i++) send(3'(i), 16'd3);
        repeat (9) step();
        total++; if (to0 !== 1'b0) $display("FAIL timeout_early got %b want 0", to0); else passed++;
        step();
        total++; if (to0 !== 1'b1) $display("FAIL timeout_flag got %b want 1", to0); else passed++;
        start();
        for (int i = 0; i < 7; i++) send(3'(i), 16'd3);
        repeat (9) step();
        send(3'd7, 16'd3);
        total++; if (fv0 !== 1'b1) $display("FAIL timeout_edge_fv got %b want 1", fv0); else passed++;
        total++; if (to0 !== 1'b0) $display("FAIL timeout_edge_err got %b want 0", to0); else passed++;
    endtask

    task automatic test_disable();
        logic [119:0] exp;
        int           pulses;
        for (int i = 0; i < 8; i++) exp[15*i +: 15] = 15'(2000 + i);
        start();
        for (int i = 0; i < 4; i++) send(3'(i), 16'(1000 + i));
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 16'(2000 + i));
            pulses += int'(fv0);
        end
        step();
        pulses += int'(fv0);
        total++; if (pulses !== 1) $display("FAIL disable_pulses got %0d want 1", pulses); else passed++;
        total++; if (concat0 !== exp) $display("FAIL disable_concat got %h want %h", concat0, exp); else passed++;
        total++; if ({dup0, to0} !== 2'b00) $display("FAIL disable_errors got %b want 00", {dup0, to0}); else passed++;
    endtask

    task automatic test_async_reset();
        start();
        for (int i = 0; i < 8; i++) send(3'(i), 16'd42);
        total++; if (fv0 !== 1'b1) $display("FAIL async_pre_fv got %b want 1", fv0); else passed++;
        resetn = 1'b0;
        #1;
        total++; if (fv0 !== 1'b0 || concat0 !== 120'd0) $display("FAIL async_reset fv %b concat %h want 0", fv0, concat0); else passed++;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_twos();
        test_offset();
        test_back_to_back();
        test_dup();
        test_timeout();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shim_abs_sample_collector.md
Name: shim_abs_sample_collector

Overview:
- Upstream stage of the per-channel threshold integrator.
- Accepts a time-multiplexed stream of signed 16-bit samples tagged with a channel index (0-7) from the DAC/ADC sample core.
- Converts each sample to a saturated 15-bit absolute value.
- Publishes all 8 channels atomically as one 120-bit frame, and flags duplicate-channel and incomplete-frame faults.

Parameters:
- OFFSET_BINARY, 0: 1 = input codes are offset binary; MSB is inverted before abs conversion. 0 = two's complement.
- TIMEOUT_CYCLES, 1024: maximum clk cycles between the first and last sample of one frame. Legal range 8..2^32-1.

Ports:
- clk  input  1  system clock; the only clock.
- resetn  input  1  reset, asynchronous, active-low.
- enable  input  1  level; high = collect frames, low = return to IDLE.
- sample_valid  input  1  sample_data and sample_ch are valid this cycle.
- sample_ch  input  3  channel index of sample_data.
- sample_data  input  16  raw sample code.
- abs_sample_concat  output  120  channel i abs value at bits [15i+14:15i]. Registered.
- frame_valid  output  1  one-cycle pulse when abs_sample_concat is updated.
- err_dup  output  1  sticky: a channel was written twice within one frame.
- err_timeout  output  1  sticky: frame not completed within TIMEOUT_CYCLES.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: abs_sample_concat=0, frame_valid=0, err_dup=0, err_timeout=0, state=IDLE, got_mask=0, timer=0, all shadow registers 0.
- Abs conversion, combinational on accept:
  - x = sample_data, with x[15] inverted if OFFSET_BINARY.
  - x>=0 -> x[14:0].
  - x<0 and x != -32768 -> (-x)[14:0].
  - x == -32768 -> 15'h7FFF (saturate).
- States: IDLE, COLLECT, ERROR.
- IDLE:
  - sample_valid ignored; got_mask=0, timer=0.
  - abs_sample_concat holds its last value.
  - enable=1 -> COLLECT on the next edge. Samples presented in that same cycle are ignored.
- COLLECT:
  - Accept at an edge where sample_valid=1.
  - If got_mask[sample_ch]=0: shadow[sample_ch] <= abs value; got_mask[sample_ch] <= 1.
  - If got_mask[sample_ch]=1: err_dup <= 1, state <= ERROR, shadow unchanged.
  - Completion: an accepted sample whose bit makes got_mask == 8'hFF. At that same edge:
    - abs_sample_concat <= all 8 shadows, with the current sample's abs value substituted for its channel.
    - frame_valid <= 1 for exactly one cycle.
    - got_mask <= 0, timer <= 0.
  - Latency: a completing sample presented in cycle N appears on abs_sample_concat, with frame_valid=1, in cycle N+1.
  - Back-to-back frames are allowed: a sample in the cycle right after completion starts a new frame.
  - Timer:
    - Set to 1 at the edge accepting the first sample of a frame (got_mask==0).
    - Increments each edge while 0 < got_mask < 8'hFF.
    - At an edge where timer == TIMEOUT_CYCLES and the frame does not complete at that edge: err_timeout <= 1, state <= ERROR.
    - Completion at the same edge wins: no error.
  - Duplicate and timeout at the same edge: both flags set, state ERROR.
  - enable=0: -> IDLE on the next edge, discarding the partial frame (got_mask=0, timer=0). A sample accepted at that edge is still processed, including a completion.
- ERROR:
  - Sticky until resetn low; enable ignored; no outputs change.
  - frame_valid=0; abs_sample_concat holds the last completed frame.
- Reset mid-frame: all state cleared immediately (asynchronous); frame_valid deasserts without waiting for a clock edge.
- Channel order within a frame is arbitrary; only set completeness matters.

Test Plan:
- Two's complement (OFFSET_BINARY=0): ch0..7 = 100, -100, 32767, -32767, -32768, 0, -1, 1 on consecutive cycles -> one cycle after ch7: abs_sample_concat fields 100, 100, 32767, 32767, 32767, 0, 1, 1; frame_valid high exactly 1 cycle.
- OFFSET_BINARY=1: codes 16'h8000, 16'h0000, 16'hFFFF on ch0-2, remaining channels 16'h8005 -> fields 0, 32767, 32767, then 5 each.
- Reverse order ch7..0 followed immediately by a second frame in order 0..7 -> two frame_valid pulses exactly 8 cycles apart; no error flags.
- ch3 sent twice before ch5 arrives -> err_dup=1 at the second ch3 edge; state ERROR; subsequent samples produce no frame_valid; asserting resetn low clears err_dup.
- TIMEOUT_CYCLES=16: 7 channels then silence -> err_timeout=1 at timer==16. Rerun with the 8th sample landing exactly at the timer==16 edge -> frame_valid, no error.
- Deassert enable after 4 channels, re-enable, send all 8 -> exactly one frame, containing only the new values; no errors.
